// File: rtl/dac_sample_scheduler.sv
// Per-period source arbiter feeding sigma_delta_dac. It picks a buffered stream sample,
// the tone code, or mid-scale, and holds that code for a whole sample period.
module dac_sample_scheduler #(
    parameter int CODE_WIDTH    = 10,
    parameter int SAMPLE_PERIOD = 1024,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CODE_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CODE_WIDTH-1:0] tone_code,
    input  logic                  tone_en,
    input  logic                  mute,
    input  logic                  underrun_clr,
    output logic [CODE_WIDTH-1:0] code,
    output logic                  sample_tick,
    output logic [1:0]            src,
    output logic [15:0]           underrun_count
);
    localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CODE_WIDTH-1:0] MID = {1'b1, {(CODE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        SRC_IDLE   = 2'd0,
        SRC_STREAM = 2'd1,
        SRC_TONE   = 2'd2,
        SRC_MUTE   = 2'd3
    } src_e;

    logic [CW-1:0]         cnt;
    logic                  tick;
    logic [CODE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           fill;
    logic                  full, empty, push, pop, underrun;
    src_e                  src_q, src_nxt;
    logic [CODE_WIDTH-1:0] code_q, code_nxt;

    assign tick        = (cnt == CW'(SAMPLE_PERIOD - 1));
    assign sample_tick = tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end

    // Flags come from registered fill, so a push in a tick cycle is seen next period.
    assign full    = (fill == (AW+1)'(FIFO_DEPTH));
    assign empty   = (fill == '0);
    assign s_ready = !full;
    assign push    = s_valid && !full;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    always_comb begin
        src_nxt  = src_q;
        code_nxt = code_q;
        pop      = 1'b0;
        underrun = 1'b0;
        if (tick) begin
            underrun = (src_q == SRC_STREAM) && empty && !mute;
            if (mute) begin
                code_nxt = MID;
                src_nxt  = SRC_MUTE;
            end else if (!empty) begin
                code_nxt = mem[rd_ptr];
                src_nxt  = SRC_STREAM;
                pop      = 1'b1;
            end else if (tone_en) begin
                code_nxt = tone_code;
                src_nxt  = SRC_TONE;
            end else begin
                src_nxt  = SRC_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q  <= SRC_IDLE;
            code_q <= MID;
        end else begin
            src_q  <= src_nxt;
            code_q <= code_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                      underrun_count <= '0;
        else if (underrun_clr)                         underrun_count <= '0;
        else if (underrun && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
    end

    assign code = code_q;
    assign src  = src_q;
endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler with a 16-cycle period and a 4-deep FIFO.
module tb_dac_sample_scheduler;
    localparam int CWD = 10;
    localparam int SP  = 16;

    logic           clk, rst;
    logic [CWD-1:0] s_data, tone_code, code;
    logic           s_valid, s_ready, tone_en, mute, underrun_clr, sample_tick;
    logic [1:0]     src;
    logic [15:0]    underrun_count;

    int nvec = 0;
    int nerr = 0;

    dac_sample_scheduler #(.CODE_WIDTH(CWD), .SAMPLE_PERIOD(SP), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .tone_code(tone_code), .tone_en(tone_en), .mute(mute), .underrun_clr(underrun_clr),
        .code(code), .sample_tick(sample_tick), .src(src), .underrun_count(underrun_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic           tone_en;
        logic [CWD-1:0] tone_code;
        logic           mute;
        logic [CWD-1:0] exp_code;
        logic [1:0]     exp_src;
        logic [15:0]    exp_ucnt;
        logic           exp_ready;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of the next tick cycle; returns cycles waited.
    task automatic to_tick(output int n);
        n = 0;
        while (!sample_tick && n < 4*SP) begin
            step();
            n++;
        end
        nvec++;
        if (!sample_tick) begin
            nerr++;
            $display("FAIL to_tick: got no tick expected tick within %0d cycles", 4*SP);
        end
    endtask

    task automatic apply_vec(input int i);
        int n;
        tone_en   = vecs[i].tone_en;
        tone_code = vecs[i].tone_code;
        mute      = vecs[i].mute;
        to_tick(n);
        step();
        chk($sformatf("v%0d_code", i), 32'(code), 32'(vecs[i].exp_code));
        chk($sformatf("v%0d_src", i), 32'(src), 32'(vecs[i].exp_src));
        chk($sformatf("v%0d_ucnt", i), 32'(underrun_count), 32'(vecs[i].exp_ucnt));
        chk($sformatf("v%0d_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
    endtask

    task automatic push(input logic [CWD-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        int n;
        //        ten  tcode  mute  code  src  ucnt  ready
        vecs[0]  = '{1'b0, 10'd0,    1'b0, 10'd100,  2'd1, 16'd0, 1'b1};
        vecs[1]  = '{1'b0, 10'd0,    1'b0, 10'd200,  2'd1, 16'd0, 1'b1};
        vecs[2]  = '{1'b0, 10'd0,    1'b0, 10'd300,  2'd1, 16'd0, 1'b1};
        vecs[3]  = '{1'b0, 10'd0,    1'b0, 10'd400,  2'd1, 16'd0, 1'b1};
        vecs[4]  = '{1'b0, 10'd0,    1'b0, 10'd400,  2'd0, 16'd1, 1'b1};
        vecs[5]  = '{1'b0, 10'd0,    1'b0, 10'd400,  2'd0, 16'd1, 1'b1};
        vecs[6]  = '{1'b1, 10'd50,   1'b1, 10'd512,  2'd3, 16'd0, 1'b1};
        vecs[7]  = '{1'b1, 10'd50,   1'b0, 10'd700,  2'd1, 16'd0, 1'b1};
        vecs[8]  = '{1'b1, 10'd1023, 1'b0, 10'd1023, 2'd2, 16'd1, 1'b1};
        vecs[9]  = '{1'b1, 10'd1023, 1'b0, 10'd1023, 2'd2, 16'd1, 1'b1};
        vecs[10] = '{1'b0, 10'd0,    1'b0, 10'd1023, 2'd0, 16'd1, 1'b1};
        vecs[11] = '{1'b1, 10'd77,   1'b0, 10'd77,   2'd2, 16'd0, 1'b1};

        rst = 1'b0; s_valid = 1'b0; s_data = '0; tone_code = '0;
        tone_en = 1'b0; mute = 1'b0; underrun_clr = 1'b0;
        @(negedge clk);
        chk("rst_code", 32'(code), 32'd512);
        chk("rst_src", 32'(src), 32'd0);
        chk("rst_ucnt", 32'(underrun_count), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_tick", 32'(sample_tick), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Idle periods: tick only in the last cycle of each period, outputs untouched.
        for (int c = 0; c < 3*SP; c++) begin
            chk($sformatf("idle_tick_c%0d", c), 32'(sample_tick), 32'((c % SP) == SP-1));
            if ((c % SP) == SP-1) begin
                chk($sformatf("idle_code_c%0d", c), 32'(code), 32'd512);
                chk($sformatf("idle_src_c%0d", c), 32'(src), 32'd0);
            end
            step();
        end

        push(10'd100);
        push(10'd200);
        push(10'd300);
        chk("burst_ready_before4", 32'(s_ready), 32'd1);
        push(10'd400);
        chk("burst_ready_full", 32'(s_ready), 32'd0);
        to_tick(n);
        chk("burst_ready_at_tick", 32'(s_ready), 32'd0);
        apply_vec(0);
        for (int i = 1; i < 6; i++) apply_vec(i);

        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("clr_ucnt", 32'(underrun_count), 32'd0);

        push(10'd700);
        for (int i = 6; i < 11; i++) apply_vec(i);

        // Push landing in a tick cycle must wait one period.
        tone_en = 1'b0; mute = 1'b0;
        to_tick(n);
        s_valid = 1'b1;
        s_data  = 10'd333;
        step();
        s_valid = 1'b0;
        chk("tickpush_src", 32'(src), 32'd0);
        chk("tickpush_code", 32'(code), 32'd1023);
        to_tick(n);
        step();
        chk("tickpush_next_code", 32'(code), 32'd333);
        chk("tickpush_next_src", 32'(src), 32'd1);

        // Clear wins over an underrun increment in the same cycle.
        to_tick(n);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("clrprio_ucnt", 32'(underrun_count), 32'd0);
        chk("clrprio_src", 32'(src), 32'd0);
        chk("clrprio_code", 32'(code), 32'd333);

        apply_vec(11);

        push(10'd11);
        push(10'd22);
        tone_en = 1'b0;
        step();
        chk("pre_rst_code", 32'(code), 32'd77);
        #2 rst = 1'b0;
        #1;
        chk("arst_code", 32'(code), 32'd512);
        chk("arst_src", 32'(src), 32'd0);
        chk("arst_ucnt", 32'(underrun_count), 32'd0);
        chk("arst_ready", 32'(s_ready), 32'd1);
        chk("arst_tick", 32'(sample_tick), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        to_tick(n);
        chk("post_rst_tick_cycle", 32'(n), 32'(SP-1));
        step();
        chk("post_rst_src", 32'(src), 32'd0);
        chk("post_rst_code", 32'(code), 32'd512);
        chk("post_rst_ready", 32'(s_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
